// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - push and decode-side handshake bundle for fetch_queue
interface fetch_queue_if;
  logic             push_ready;
  logic [1:0]       push_valid;
  logic [1:0][31:0] push_inst;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       accepted;

  modport master (
    input  push_ready, out_valid, out_inst, out_pc,
    output push_valid, push_inst, accepted
  );

  modport slave (
    output push_ready, out_valid, out_inst, out_pc,
    input  push_valid, push_inst, accepted
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-wide in-order fetch queue owning the fetch PC
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int          DEPTH     = 8,
  parameter int          DEPTH_LOG = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic [31:0]        fetch_pc,
  output logic [DEPTH_LOG:0] occupancy,
  fetch_queue_if.slave       bus
);

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;

  localparam cnt_t PUSH_LIMIT = cnt_t'(DEPTH - 2);
  localparam cnt_t CNT_FULL   = cnt_t'(DEPTH);

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  ptr_t rd_ptr, wr_ptr, rd_ptr1, wr_addr1;
  cnt_t count;

  logic             push_ready;
  logic             push_ok;
  logic             bypass_active;
  logic [1:0]       n_push, n_pop, n_skip;
  logic [1:0]       we;
  logic [1:0]       valid_v;
  logic [1:0][31:0] inst_v, pc_v;

  assign rd_ptr1    = rd_ptr + ptr_t'(1);
  assign push_ready = (count <= PUSH_LIMIT);
  assign push_ok    = push_ready & bus.push_valid[0];
  assign n_push     = push_ok ? (bus.push_valid[1] ? 2'd2 : 2'd1) : 2'd0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_active = (count == '0) && !flush;
`else
  assign bypass_active = 1'b0;
`endif

  always_comb begin
    valid_v[0] = (count != '0);
    valid_v[1] = (count >= cnt_t'(2));
    inst_v     = {inst_mem[rd_ptr1], inst_mem[rd_ptr]};
    pc_v       = {pc_mem[rd_ptr1], pc_mem[rd_ptr]};
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: the incoming fetch group is presented directly.
    if (bypass_active) begin
      valid_v[0] = push_ok;
      valid_v[1] = push_ok & bus.push_valid[1];
      inst_v     = bus.push_inst;
      pc_v       = {fetch_pc + 32'd4, fetch_pc};
    end
`endif
    for (int k = 0; k < 2; k++) begin
      bus.out_inst[k] = valid_v[k] ? inst_v[k] : 32'd0;
      bus.out_pc[k]   = valid_v[k] ? pc_v[k]   : 32'd0;
    end
    if (bus.accepted[0] & valid_v[0])
      n_pop = (bus.accepted[1] & valid_v[1]) ? 2'd2 : 2'd1;
    else
      n_pop = 2'd0;
    // Bypassed instructions consumed this cycle never touch storage.
    n_skip = bypass_active ? n_pop : 2'd0;
  end

  assign bus.out_valid  = valid_v;
  assign bus.push_ready = push_ready;
  assign occupancy      = count;

  assign we[0]    = !flush && (n_push != 2'd0) && (n_skip == 2'd0);
  assign we[1]    = !flush && (n_push == 2'd2) && (n_skip != 2'd2);
  assign wr_addr1 = (n_skip == 2'd0) ? wr_ptr + ptr_t'(1) : wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= flush_pc;
    end else begin
      wr_ptr   <= wr_ptr + ptr_t'(n_push - n_skip);
      rd_ptr   <= rd_ptr + ptr_t'(n_pop - n_skip);
      count    <= count + cnt_t'(n_push) - cnt_t'(n_pop);
      fetch_pc <= fetch_pc + {28'd0, n_push, 2'b00};
    end
  end

  // Storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (we[0]) begin
      inst_mem[wr_ptr] <= bus.push_inst[0];
      pc_mem[wr_ptr]   <= fetch_pc;
    end
    if (we[1]) begin
      inst_mem[wr_addr1] <= bus.push_inst[1];
      pc_mem[wr_addr1]   <= fetch_pc + 32'd4;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CNT_FULL);
      if (!bypass_active) assert (cnt_t'(n_pop) <= count);
    end
  end
`endif

endmodule
